// File: rtl/balu_seq.sv
// Handshaked bit-manipulation unit: single-bit, rotate and byte ops in one
// cycle; CLZ/CTZ/CPOP iterate CHUNK bits per cycle with a fixed latency.
module balu_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] num1,
  input  logic [XLEN-1:0] num2,
  input  logic [7:0]      mode_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ans,
  output logic            error,
  output logic            busy
);

  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned N     = XLEN / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned CW    = $clog2(CHUNK + 1);
  localparam int unsigned NB    = XLEN / 8;

  localparam logic [7:0] M_BCLR = 8'h30;
  localparam logic [7:0] M_BEXT = 8'h31;
  localparam logic [7:0] M_BINV = 8'h32;
  localparam logic [7:0] M_BSET = 8'h33;
  localparam logic [7:0] M_CLZ  = 8'h34;
  localparam logic [7:0] M_CPOP = 8'h35;
  localparam logic [7:0] M_CTZ  = 8'h36;
  localparam logic [7:0] M_ROL  = 8'h37;
  localparam logic [7:0] M_ROR  = 8'h38;
  localparam logic [7:0] M_REV8 = 8'h39;
  localparam logic [7:0] M_ORCB = 8'h3A;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COUNT = 2'd1, S_DONE = 2'd2} state_e;
  typedef enum logic [1:0] {C_CLZ = 2'd0, C_CTZ = 2'd1, C_CPOP = 2'd2} cop_e;

  state_e           state_q, state_d;
  cop_e             cop_q, cop_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  ans_q, ans_d;
  logic             error_q, error_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             found_q, found_d;

  logic [SH_W-1:0]   sh;
  logic [XLEN-1:0]   bit_mask;
  logic [2*XLEN-1:0] rol_dbl, ror_dbl;
  logic [XLEN-1:0]   rev8_res, orcb_res;
  logic [XLEN-1:0]   simple_res;
  logic              simple_err;
  logic              is_count;
  cop_e              cop_sel;
  logic [CHUNK-1:0]  chunk_hi, chunk_lo;
  logic              unused_num2;

  assign sh          = num2[SH_W-1:0];
  assign unused_num2 = ^num2[XLEN-1:SH_W];
  assign chunk_hi    = opnd_q[XLEN-1 -: CHUNK];
  assign chunk_lo    = opnd_q[CHUNK-1:0];

  function automatic logic [CW-1:0] lz_chunk(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!hit) begin
        if (c[i]) hit = 1'b1;
        else      n   = n + CW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] tz_chunk(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (!hit) begin
        if (c[i]) hit = 1'b1;
        else      n   = n + CW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] pop_chunk(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) n = n + CW'(c[i]);
    return n;
  endfunction

  // Single-cycle results; rotates use a doubled operand so no shift reaches XLEN
  always_comb begin
    bit_mask = XLEN'(1) << sh;
    rol_dbl  = {num1, num1} << sh;
    ror_dbl  = {num1, num1} >> sh;
    rev8_res = '0;
    orcb_res = '0;
    for (int b = 0; b < NB; b++) begin
      rev8_res[8*b +: 8] = num1[XLEN-8-8*b +: 8];
      orcb_res[8*b +: 8] = {8{|num1[8*b +: 8]}};
    end
    simple_res = '0;
    simple_err = 1'b0;
    is_count   = 1'b0;
    cop_sel    = C_CLZ;
    case (mode_sel)
      M_BCLR: simple_res = num1 & ~bit_mask;
      M_BEXT: simple_res = {{(XLEN-1){1'b0}}, num1[sh]};
      M_BINV: simple_res = num1 ^ bit_mask;
      M_BSET: simple_res = num1 | bit_mask;
      M_CLZ:  begin is_count = 1'b1; cop_sel = C_CLZ;  end
      M_CPOP: begin is_count = 1'b1; cop_sel = C_CPOP; end
      M_CTZ:  begin is_count = 1'b1; cop_sel = C_CTZ;  end
      M_ROL:  simple_res = rol_dbl[2*XLEN-1:XLEN];
      M_ROR:  simple_res = ror_dbl[XLEN-1:0];
      M_REV8: simple_res = rev8_res;
      M_ORCB: simple_res = orcb_res;
      default: simple_err = 1'b1;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cop_d       = cop_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    ans_d       = ans_q;
    error_d     = error_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    found_d     = found_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (is_count) begin
            opnd_d  = num1;
            cop_d   = cop_sel;
            acc_d   = '0;
            idx_d   = '0;
            found_d = 1'b0;
            busy_d  = 1'b1;
            state_d = S_COUNT;
          end else begin
            ans_d       = simple_res;
            error_d     = simple_err;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_COUNT: begin
        idx_d = idx_q + IDX_W'(1);
        case (cop_q)
          C_CLZ: begin
            opnd_d = opnd_q << CHUNK;
            if (!found_q) begin
              if (chunk_hi == '0) acc_d = acc_q + CNT_W'(CHUNK);
              else begin
                acc_d   = acc_q + CNT_W'(lz_chunk(chunk_hi));
                found_d = 1'b1;
              end
            end
          end
          C_CTZ: begin
            opnd_d = opnd_q >> CHUNK;
            if (!found_q) begin
              if (chunk_lo == '0) acc_d = acc_q + CNT_W'(CHUNK);
              else begin
                acc_d   = acc_q + CNT_W'(tz_chunk(chunk_lo));
                found_d = 1'b1;
              end
            end
          end
          default: begin
            opnd_d = opnd_q >> CHUNK;
            acc_d  = acc_q + CNT_W'(pop_chunk(chunk_lo));
          end
        endcase
        if (idx_q == IDX_W'(N - 1)) begin
          ans_d       = XLEN'(acc_d);
          error_d     = 1'b0;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase

    // Abort wins over any accept or hand-off this cycle
    if (flush) begin
      state_d     = S_IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cop_q       <= C_CLZ;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ans_q       <= '0;
      error_q     <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cop_q       <= cop_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ans_q       <= ans_d;
      error_q     <= error_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ans       = ans_q;
  assign error     = error_q;

endmodule

// File: tb/tb_balu_seq.sv
// Scoreboard bench for balu_seq: directed cases, flush/reset aborts, a 64-bit
// count instance and randomised traffic under out_ready back-pressure.
module tb_balu_seq;

  typedef struct {
    logic [31:0] ans;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num1, num2;
  logic [7:0]  mode_sel;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ans;
  logic        error;
  logic        busy;

  logic        iv64, ir64, ov64, err64, busy64;
  logic [63:0] a64, b64, ans64;
  logic [7:0]  mode64;

  int   n_cmp = 0;
  int   n_err = 0;
  int   bp_mode = 0;
  exp_t q[$];

  balu_seq u_dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .mode_sel(mode_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .ans(ans), .error(error), .busy(busy)
  );

  balu_seq #(.XLEN(64), .CHUNK(16)) u_dut64 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(iv64), .in_ready(ir64),
    .num1(a64), .num2(b64), .mode_sel(mode64),
    .out_valid(ov64), .out_ready(1'b1),
    .ans(ans64), .error(err64), .busy(busy64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    int unsigned s;
    s     = b[4:0];
    r.ans = '0;
    r.err = 1'b0;
    case (m)
      8'h30: r.ans = a & ~(32'h1 << s);
      8'h31: r.ans = 32'(a[s]);
      8'h32: r.ans = a ^ (32'h1 << s);
      8'h33: r.ans = a | (32'h1 << s);
      8'h34: begin
        r.ans = 32'd32;
        for (int i = 0; i < 32; i++) if (a[i]) r.ans = 32'(31 - i);
      end
      8'h35: r.ans = 32'($countones(a));
      8'h36: begin
        r.ans = 32'd32;
        for (int i = 31; i >= 0; i--) if (a[i]) r.ans = 32'(i);
      end
      8'h37: r.ans = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      8'h38: r.ans = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      8'h39: r.ans = {a[7:0], a[15:8], a[23:16], a[31:24]};
      8'h3A: for (int k = 0; k < 4; k++) r.ans[8*k +: 8] = (a[8*k +: 8] != 8'h00) ? 8'hFF : 8'h00;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Output side of the scoreboard: compare on every completed hand-off
  always @(negedge clk) begin
    if (rstn && !flush && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("ans", 64'(ans), 64'(e.ans));
        chk("error", 64'(error), 64'(e.err));
      end
    end
  end

  task automatic send(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int w;
    int lat;
    @(posedge clk); #1;
    mode_sel = m; num1 = a; num2 = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; num1 = $urandom; num2 = $urandom; mode_sel = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), (m == 8'h34 || m == 8'h35 || m == 8'h36) ? 64'd5 : 64'd1);
  endtask

  task automatic send64(input logic [7:0] m, input logic [63:0] a, input logic [63:0] e);
    int w;
    int lat;
    @(posedge clk); #1;
    mode64 = m; a64 = a; b64 = '0; iv64 = 1'b1;
    w = 0;
    while (!ir64 && w < 100) begin @(posedge clk); #1; w++; end
    if (!ir64) chk("accept64_timeout", 64'(ir64), 64'd1);
    @(posedge clk); #1;
    iv64 = 1'b0; a64 = '1;
    lat = 1;
    while (!ov64 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("latency64", 64'(lat), 64'd5);
    chk("ans64", ans64, e);
    chk("error64", 64'(err64), 64'd0);
  endtask

  // Starts a count op without a scoreboard entry; returns one cycle into COUNT
  task automatic start_count(input logic [31:0] a);
    int w;
    @(posedge clk); #1;
    mode_sel = 8'h34; num1 = a; num2 = '0; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_in_count", 64'(busy), 64'd1);
  endtask

  initial begin
    logic seen;
    int   w;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    num1 = '0; num2 = '0; mode_sel = '0;
    iv64 = 1'b0; a64 = '0; b64 = '0; mode64 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ans", 64'(ans), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_busy64", 64'(busy64), 64'd0);
    @(negedge clk) rstn = 1'b1;

    send(8'h33, 32'h0, 32'd31, '{32'h8000_0000, 1'b0});
    send(8'h34, 32'h0000_0100, 32'h0, '{32'd23, 1'b0});
    send(8'h34, 32'h0, 32'h0, '{32'd32, 1'b0});
    send(8'h36, 32'h0, 32'h0, '{32'd32, 1'b0});
    send(8'h36, 32'h8000_0000, 32'h0, '{32'd31, 1'b0});
    send(8'h37, 32'h8000_0001, 32'd0, '{32'h8000_0001, 1'b0});
    send(8'h37, 32'h8000_0001, 32'd1, '{32'h0000_0003, 1'b0});
    send(8'h38, 32'h8000_0001, 32'd33, '{32'hC000_0000, 1'b0});
    send(8'h39, 32'h1122_3344, 32'h0, '{32'h4433_2211, 1'b0});
    send(8'h3A, 32'h0001_0000, 32'h0, '{32'h00FF_0000, 1'b0});
    send(8'h31, 32'h0000_0020, 32'd5, '{32'h0000_0001, 1'b0});
    send(8'h30, 32'hFFFF_FFFF, 32'd0, '{32'hFFFF_FFFE, 1'b0});
    send(8'h32, 32'h0000_00F0, 32'd4, '{32'h0000_00E0, 1'b0});
    send(8'h7F, 32'hDEAD_BEEF, 32'h3, '{32'h0, 1'b1});

    // Result held under back-pressure
    bp_mode = 2;
    send(8'h35, 32'hF0F0_0001, 32'h0, '{32'd9, 1'b0});
    for (int i = 0; i < 10; i++) begin
      chk("hold_ans", 64'(ans), 64'd9);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    bp_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);

    // Flush in the second COUNT cycle
    start_count(32'h0000_0100);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | out_valid;
      @(posedge clk); #1;
    end
    chk("flush_no_out", 64'(seen), 64'd0);

    // Asynchronous reset mid-COUNT
    start_count(32'h0);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ans", 64'(ans), 64'd0);
    chk("arst_error", 64'(error), 64'd0);
    @(negedge clk) rstn = 1'b1;

    send64(8'h34, 64'h1, 64'd63);
    send64(8'h36, 64'h0, 64'd64);
    send64(8'h35, 64'hFFFF_0000_0000_0001, 64'd17);

    bp_mode = 1;
    for (int n = 0; n < 2000; n++) begin
      logic [7:0]  m;
      logic [31:0] a, b;
      int          sel;
      sel = $urandom_range(0, 13);
      m   = (sel < 11) ? 8'(8'h30 + sel) : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 32'h0;
        1:       a = 32'h1 << $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      b = $urandom;
      send(m, a, b, model(m, a, b));
    end

    w = 0;
    while (q.size() != 0 && w < 200) begin @(posedge clk); w++; end
    chk("drain_q", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
